// File: rtl/adder_tree_l0_sched_pkg.sv
// Shared definitions for the level-0 multiplier chunk scheduler.
package adder_tree_l0_sched_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_DRAIN = 2'd2,
    SCHED_DONE  = 2'd3
  } sched_state_e;

  // Each chunk is 16 lanes x INT16 = 256-bit operand per side.
  localparam int L0_LANES     = 16;
  localparam int L0_ELEM_W    = 16;
  localparam int L0_OPERAND_W = L0_LANES * L0_ELEM_W;

endpackage

// File: rtl/adder_tree_l0_sched_l0_valid_pipe.sv
// Fixed-depth shift line for {valid, last} tracking reads through the SRAM + L0 register.
// Latency DEPTH cycles; no backpressure, clear flushes every stage.
module l0_valid_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/adder_tree_l0_sched.sv
// Chunk scheduler: issues A/B operand reads per job, tags the last chunk, tracks downstream credits.
// mul_valid lags rd_en by PIPE_LAT cycles; issue stalls while the credit counter is zero.
module adder_tree_l0_sched
  import adder_tree_l0_sched_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int LEN_W    = 10,
  parameter int CREDITS  = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic              clear,
  input  logic              credit_ret,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              mul_valid,
  output logic              mul_last,
  output logic              busy,
  output logic              done,
  output logic              cred_err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  sched_state_e      state, state_nxt;
  logic [LEN_W-1:0]  cnt, len_q;
  logic [ADDR_W-1:0] base_a_q, base_b_q;
  logic [CW-1:0]     credit_cnt;
  logic              cred_err_q;
  logic              issue, last_tag;
  logic [1:0]        pipe_out;

  assign issue    = (state == SCHED_ISSUE) && (credit_cnt != '0);
  assign last_tag = issue && (cnt == len_q - LEN_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      SCHED_IDLE:  if (start) state_nxt = (vec_len != '0) ? SCHED_ISSUE : SCHED_DONE;
      SCHED_ISSUE: if (last_tag) state_nxt = SCHED_DRAIN;
      SCHED_DRAIN: if (mul_last) state_nxt = SCHED_DONE;
      SCHED_DONE:  state_nxt = SCHED_IDLE;
      default:     state_nxt = SCHED_IDLE;
    endcase
    if (clear) state_nxt = SCHED_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= SCHED_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      len_q    <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (state == SCHED_IDLE && start) begin
      cnt      <= '0;
      len_q    <= vec_len;
      base_a_q <= base_a;
      base_b_q <= base_b;
    end else if (issue) begin
      cnt <= cnt + LEN_W'(1);
    end
  end

  // Downstream flushes its buffer on clear, so all credits come back at once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      credit_cnt <= CRED_MAX;
      cred_err_q <= 1'b0;
    end else begin
      if (clear)
        credit_cnt <= CRED_MAX;
      else if (issue && !credit_ret)
        credit_cnt <= credit_cnt - CW'(1);
      else if (!issue && credit_ret && credit_cnt != CRED_MAX)
        credit_cnt <= credit_cnt + CW'(1);
      if (credit_ret && !issue && credit_cnt == CRED_MAX)
        cred_err_q <= 1'b1;
    end
  end

  l0_valid_pipe #(
    .DEPTH(PIPE_LAT),
    .WIDTH(2)
  ) u_valid_pipe (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .din  ({issue, last_tag}),
    .dout (pipe_out)
  );

  assign rd_en     = issue;
  assign rd_addr_a = issue ? base_a_q + ADDR_W'(cnt) : '0;
  assign rd_addr_b = issue ? base_b_q + ADDR_W'(cnt) : '0;
  assign mul_valid = pipe_out[1];
  assign mul_last  = pipe_out[1] & pipe_out[0];
  assign busy      = (state == SCHED_ISSUE) || (state == SCHED_DRAIN);
  assign done      = (state == SCHED_DONE);
  assign cred_err  = cred_err_q;

endmodule

// File: tb/tb_adder_tree_l0_sched.sv
// Scoreboard bench: jobs push expected reads/products/done; a negedge monitor pops and compares.
module tb_adder_tree_l0_sched;

  localparam int PIPE_LAT = 2;
  localparam int NCRED    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       credit_ret = 1'b0;
  logic [9:0] vec_len = '0;
  logic [9:0] base_a = '0;
  logic [9:0] base_b = '0;
  logic       rd_en, mul_valid, mul_last, busy, done, cred_err;
  logic [9:0] rd_addr_a, rd_addr_b;

  adder_tree_l0_sched dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .vec_len   (vec_len),
    .base_a    (base_a),
    .base_b    (base_b),
    .clear     (clear),
    .credit_ret(credit_ret),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .mul_valid (mul_valid),
    .mul_last  (mul_last),
    .busy      (busy),
    .done      (done),
    .cred_err  (cred_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0, nfail = 0;
  int rd_count = 0, done_cnt = 0;
  int mdl_cred = NCRED;
  bit mdl_err = 1'b0;

  logic [9:0] q_a[$], q_b[$];
  bit         q_last[$];
  int         m_cyc[$];
  bit         m_last[$];
  int         d_cyc[$];

  logic [9:0] ea, eb;
  bit         el;
  int         ec;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flush_model();
    q_a.delete(); q_b.delete(); q_last.delete();
    m_cyc.delete(); m_last.delete(); d_cyc.delete();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      flush_model();
      mdl_cred = NCRED;
      mdl_err  = 1'b0;
    end else begin
      chk("cred_err", cred_err, mdl_err);
      if (rd_en) begin
        rd_count++;
        if (q_a.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          ea = q_a.pop_front(); eb = q_b.pop_front(); el = q_last.pop_front();
          chk("rd_addr_a", rd_addr_a, ea);
          chk("rd_addr_b", rd_addr_b, eb);
          chk("rd_credit_avail", int'(mdl_cred > 0), 1);
          m_cyc.push_back(cyc + PIPE_LAT);
          m_last.push_back(el);
        end
      end else if (busy && q_a.size() > 0 && mdl_cred > 0) begin
        chk("rd_bubble", 0, 1);
      end
      if (mul_valid) begin
        if (m_cyc.size() == 0) chk("mul_unexpected", 1, 0);
        else begin
          ec = m_cyc.pop_front(); el = m_last.pop_front();
          chk("mul_cycle", cyc, ec);
          chk("mul_last", mul_last, el);
          if (el) d_cyc.push_back(cyc + 1);
        end
      end else if (m_cyc.size() > 0 && m_cyc[0] < cyc) begin
        chk("mul_missing", 0, 1);
        void'(m_cyc.pop_front()); void'(m_last.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", busy, 0);
        if (d_cyc.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          ec = d_cyc.pop_front();
          chk("done_cycle", cyc, ec);
        end
      end else if (d_cyc.size() > 0 && d_cyc[0] < cyc) begin
        chk("done_missing", 0, 1);
        void'(d_cyc.pop_front());
      end
      // Credit bookkeeping from the rules: issue takes one, a return gives one back, saturating.
      if (credit_ret && !rd_en && mdl_cred == NCRED) mdl_err = 1'b1;
      if (clear) begin
        mdl_cred = NCRED;
        flush_model();
      end else if (rd_en && !credit_ret) begin
        mdl_cred--;
      end else if (!rd_en && credit_ret && mdl_cred < NCRED) begin
        mdl_cred++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pick_ret(input int mode);
    if (mode == 1) return mdl_cred < NCRED;
    if (mode == 2) return (mdl_cred < NCRED) && ($urandom_range(0, 1) == 1);
    return 1'b0;
  endfunction

  task automatic refill();
    int g = 0;
    while (mdl_cred < NCRED && g < 50) begin
      credit_ret = 1'b1;
      tick();
      g++;
    end
    credit_ret = 1'b0;
  endtask

  task automatic issue_start(input int len, input int a, input int b, input int mode);
    logic [9:0] addr;
    start      = 1'b1;
    vec_len    = 10'(len);
    base_a     = 10'(a);
    base_b     = 10'(b);
    credit_ret = pick_ret(mode);
    for (int i = 0; i < len; i++) begin
      addr = 10'((a + i) % 1024); q_a.push_back(addr);
      addr = 10'((b + i) % 1024); q_b.push_back(addr);
      q_last.push_back(i == len - 1);
    end
    if (len == 0) d_cyc.push_back(cyc + 1);
    tick();
    start = 1'b0;
  endtask

  // Junk start requests during the job must be ignored.
  task automatic wait_done(input int mode, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 400) begin
      credit_ret = pick_ret(mode);
      start      = ($urandom_range(0, 3) == 0);
      vec_len    = 10'($urandom);
      base_a     = 10'($urandom);
      base_b     = 10'($urandom);
      tick();
      n++;
    end
    start      = 1'b0;
    credit_ret = 1'b0;
    if (done_cnt == d0) chk("job_timeout", 0, 1);
  endtask

  task automatic run_job(input int len, input int a, input int b, input int mode);
    int d0 = done_cnt;
    issue_start(len, a, b, mode);
    wait_done(mode, d0);
  endtask

  int r0, d0;

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_addr_a", rd_addr_a, 0);
    chk("rst_addr_b", rd_addr_b, 0);
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_mul_last", mul_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cred_err", cred_err, 0);

    // Basic three-chunk job with steady credit return
    run_job(3, 'h010, 'h200, 1);

    // Credit stall: four reads on reset credits, then one read per returned credit
    refill();
    r0 = rd_count; d0 = done_cnt;
    issue_start(6, 'h040, 'h080, 0);
    repeat (8) tick();
    chk("t3_stall_reads", rd_count - r0, 4);
    chk("t3_busy", busy, 1);
    chk("t3_rd_stalled", rd_en, 0);
    credit_ret = 1'b1; tick(); credit_ret = 1'b0;
    repeat (4) tick();
    chk("t3_one_more", rd_count - r0, 5);
    credit_ret = 1'b1; tick(); credit_ret = 1'b0;
    wait_done(0, d0);
    chk("t3_total_reads", rd_count - r0, 6);

    // Address wrap
    refill();
    run_job(4, 'h3FE, 'h155, 2);

    // Clear on the second read, then an immediate restart on the restored credits
    refill();
    r0 = rd_count; d0 = done_cnt;
    issue_start(5, 'h100, 'h120, 1);
    credit_ret = pick_ret(1);
    tick();
    chk("t5_rd_at_clear", rd_en, 1);
    clear = 1'b1;
    credit_ret = pick_ret(1);
    tick();
    clear = 1'b0;
    credit_ret = 1'b0;
    chk("t5_busy_after_clear", busy, 0);
    chk("t5_reads_before_clear", rd_count - r0, 2);
    chk("t5_no_done", done_cnt - d0, 0);
    r0 = rd_count; d0 = done_cnt;
    issue_start(4, 'h300, 'h301, 0);
    wait_done(0, d0);
    chk("t5_restart_reads", rd_count - r0, 4);

    // Randomised jobs with random credit returns
    for (int j = 0; j < 10; j++)
      run_job($urandom_range(1, 12), $urandom_range(0, 1023), $urandom_range(0, 1023), 2);

    // Zero-length job, then an over-return that latches the sticky error until reset
    refill();
    r0 = rd_count;
    run_job(0, 'h020, 'h030, 0);
    chk("t6_no_reads", rd_count - r0, 0);
    credit_ret = 1'b1; tick(); credit_ret = 1'b0;
    tick();
    chk("t6_cred_err_set", cred_err, 1);
    run_job(2, 'h011, 'h022, 2);
    chk("t6_cred_err_held", cred_err, 1);
    repeat (PIPE_LAT + 2) tick();
    chk("queues_empty", q_a.size() + m_cyc.size() + d_cyc.size(), 0);

    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("t6_cred_err_cleared", cred_err, 0);
    chk("t6_busy_cleared", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
